// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Definitions shared by the keypad scanner and the keypad reader:
//   - row drive and column one-hot-low codes
//   - debounce FSM state encodings
//   - default debounce depth in scan frames
//   - helpers that decode a one-hot-low nibble
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int unsigned DEB_FRAMES_DEFAULT = 3;

   // Row drive codes (active-low one-hot); ROW_IDLE means no row is driven
   localparam logic [3:0] ROW0_SCAN = 4'b1110;
   localparam logic [3:0] ROW1_SCAN = 4'b1101;
   localparam logic [3:0] ROW2_SCAN = 4'b1011;
   localparam logic [3:0] ROW3_SCAN = 4'b0111;
   localparam logic [3:0] ROW_IDLE  = 4'b1111;

   // Column codes (active-low, pulled high)
   localparam logic [3:0] COL0_HIT  = 4'b1110;
   localparam logic [3:0] COL1_HIT  = 4'b1101;
   localparam logic [3:0] COL2_HIT  = 4'b1011;
   localparam logic [3:0] COL3_HIT  = 4'b0111;
   localparam logic [3:0] COL_IDLE  = 4'b1111;

   // Debounce FSM state encodings
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_PRESSED  = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   // True when exactly one bit of v is low
   function automatic logic is_onehot_low(input logic [3:0] v);
      logic r;
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // Index of the low bit of a one-hot-low nibble (0 when not one-hot-low)
   function automatic logic [1:0] onehot_low_idx(input logic [3:0] v);
      logic [1:0] r;
      case (v)
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/keypad_reader_frame.sv
// -----------------------------------------------------------------------------
// keypad_frame
// Accumulates the column samples of one row3..row0..row3 scan frame and
// reports the frame result when the row3 sample arrives.
//   clk, rst_n   system clock, asynchronous active-low reset
//   row_scan     active-low one-hot row drive
//   cnt_end      scan-step strobe; row_scan/col_in valid when high
//   col_in       active-low columns
//   frame_done   high in the cycle of the valid row3 sample
//   frame_hit    with frame_done: exactly one key seen in the frame
//   frame_key    code row*4+col of that key
// Frame outputs are combinational from the accumulator plus the current
// sample, so the caller's registers land one clock after the deciding sample.
// -----------------------------------------------------------------------------
module keypad_frame
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_scan,
   input  logic       cnt_end,
   input  logic [3:0] col_in,
   output logic       frame_done,
   output logic       frame_hit,
   output logic [3:0] frame_key
);

   logic       acc_hit;
   logic       acc_multi;
   logic [3:0] acc_key;

   logic       sample_ok;
   logic       col_hit;
   logic       col_multi;
   logic [3:0] smp_key;
   logic       nx_hit;
   logic       nx_multi;
   logic [3:0] nx_key;

   always_comb begin
      sample_ok = cnt_end & is_onehot_low(row_scan);
      col_hit   = is_onehot_low(col_in);
      col_multi = ~col_hit & (col_in != COL_IDLE);
      smp_key   = {onehot_low_idx(row_scan), onehot_low_idx(col_in)};

      // A second hit only counts as ghosting if it names a different key,
      // so a row sampled twice with the same key stays a single hit.
      nx_multi  = acc_multi | col_multi | (acc_hit & col_hit & (smp_key != acc_key));
      nx_hit    = acc_hit | col_hit;
      nx_key    = col_hit ? smp_key : acc_key;

      frame_done = sample_ok & (row_scan == ROW3_SCAN);
      frame_hit  = frame_done & nx_hit & ~nx_multi;
      frame_key  = nx_key;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hit   <= 1'b0;
         acc_multi <= 1'b0;
         acc_key   <= '0;
      end else if (sample_ok) begin
         if (frame_done) begin
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_key   <= '0;
         end else begin
            acc_hit   <= nx_hit;
            acc_multi <= nx_multi;
            acc_key   <= nx_key;
         end
      end
   end

endmodule

// File: rtl/keypad_reader.sv
// -----------------------------------------------------------------------------
// keypad_reader
// Debounced 4x4 keypad reader: frame results from keypad_frame drive a
// press/release debounce FSM with registered outputs.
//   DEB_FRAMES   identical frames needed to accept a press or release (2..15)
//   clk, rst_n   system clock, asynchronous active-low reset
//   row_scan     active-low one-hot row drive from the scanner
//   cnt_end      scan-step strobe
//   col_in       active-low keypad columns
//   key_code     code of the last accepted key (row*4+col)
//   key_valid    one-cycle pulse on press acceptance
//   key_down     level, high while an accepted key is held
//   key_release  one-cycle pulse on release acceptance
// -----------------------------------------------------------------------------
module keypad_reader
   import keypad_pkg::*;
#(
   parameter int unsigned DEB_FRAMES = DEB_FRAMES_DEFAULT
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_scan,
   input  logic       cnt_end,
   input  logic [3:0] col_in,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output logic       key_release
);

   localparam logic [3:0] DEB_LIM = 4'(DEB_FRAMES);

   logic       frame_done;
   logic       frame_hit;
   logic [3:0] frame_key;

   logic [1:0] state;
   logic [3:0] cand;
   logic [3:0] cnt;
   logic [3:0] cnt_inc;

   keypad_frame u_frame (
      .clk        (clk),
      .rst_n      (rst_n),
      .row_scan   (row_scan),
      .cnt_end    (cnt_end),
      .col_in     (col_in),
      .frame_done (frame_done),
      .frame_hit  (frame_hit),
      .frame_key  (frame_key)
   );

   always_comb cnt_inc = cnt + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cand        <= '0;
         cnt         <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_down    <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         if (frame_done) begin
            case (state)
               ST_IDLE: begin
                  if (frame_hit) begin
                     state <= ST_DEBOUNCE;
                     cand  <= frame_key;
                     cnt   <= 4'd1;
                  end
               end
               ST_DEBOUNCE: begin
                  if (!frame_hit) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end else if (frame_key != cand) begin
                     cand <= frame_key;
                     cnt  <= 4'd1;
                  end else if (cnt_inc == DEB_LIM) begin
                     state     <= ST_PRESSED;
                     cnt       <= '0;
                     key_code  <= cand;
                     key_valid <= 1'b1;
                     key_down  <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               ST_PRESSED: begin
                  // Any key frame keeps the held key; no roll-over.
                  if (!frame_hit) begin
                     state <= ST_RELEASE;
                     cnt   <= 4'd1;
                  end
               end
               ST_RELEASE: begin
                  if (frame_hit) begin
                     state <= ST_PRESSED;
                     cnt   <= '0;
                  end else if (cnt_inc == DEB_LIM) begin
                     state       <= ST_IDLE;
                     cnt         <= '0;
                     key_release <= 1'b1;
                     key_down    <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_reader.sv
module tb_keypad_reader;
   import keypad_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_scan;
   logic       cnt_end;
   logic [3:0] col_in;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       key_release;

   always #5 clk = ~clk;

   keypad_reader #(.DEB_FRAMES(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_scan    (row_scan),
      .cnt_end     (cnt_end),
      .col_in      (col_in),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_down    (key_down),
      .key_release (key_release)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected output event: release flag, key_code, key_down, cycle stamp
   typedef struct packed {
      logic        rel;
      logic [3:0]  code;
      logic        down;
      logic [31:0] at;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  last_cyc = 0;
   logic [3:0] rows [4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Column pattern per row (row r in bits [4r+3:4r]) for a single key k
   function automatic logic [15:0] key_cols(input int k);
      logic [15:0] c;
      logic [3:0]  one;
      one = 4'b0001;
      c = '1;
      c[4*(k/4) +: 4] = ~(one << (k % 4));
      return c;
   endfunction

   // One full frame; each row sample is preceded by a gap cycle that is
   // either unstrobed or (junk=1) a strobed sample with row_scan idle.
   task automatic frame(input logic [15:0] cols, input bit junk);
      for (int r = 0; r < 4; r++) begin
         cnt_end  = junk;
         row_scan = ROW_IDLE;
         col_in   = junk ? 4'b0000 : 4'($urandom);
         @(posedge clk); #1;
         row_scan = rows[r];
         col_in   = cols[4*r +: 4];
         cnt_end  = 1'b1;
         @(posedge clk); #1;
      end
      cnt_end  = 1'b0;
      row_scan = ROW_IDLE;
      col_in   = COL_IDLE;
      last_cyc = cyc;
   endtask

   task automatic key_frames(input int k, input int n, input bit junk);
      for (int i = 0; i < n; i++) frame(key_cols(k), junk);
   endtask

   task automatic none_frames(input int n);
      for (int i = 0; i < n; i++) frame(16'hFFFF, 1'b0);
   endtask

   task automatic expect_ev(input bit rel, input logic [3:0] code);
      ev_t e;
      e.rel  = rel;
      e.code = code;
      e.down = ~rel;
      e.at   = 32'(last_cyc);
      exp_q.push_back(e);
   endtask

   // Scoreboard: every pulse must match the oldest expected event
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (key_valid || key_release) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_bad++;
               $error("FAIL unexpected_pulse: observed valid=%b release=%b code=%h expected no pulse",
                      key_valid, key_release, key_code);
            end
            if (exp_q.size() != 0) begin
               ev_t e, g;
               e = exp_q.pop_front();
               g.rel  = key_release;
               g.code = key_code;
               g.down = key_down;
               g.at   = 32'(cyc);
               check(key_release ? "release_event" : "press_event", 64'(g), 64'(e));
               check("pulse_kind", {63'd0, key_valid}, {63'd0, ~e.rel});
            end
         end
         check("valid_release_exclusive", {63'd0, key_valid & key_release}, 64'd0);
      end
   end

   initial begin
      rows[0] = ROW0_SCAN; rows[1] = ROW1_SCAN; rows[2] = ROW2_SCAN; rows[3] = ROW3_SCAN;

      // Reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         row_scan = 4'($urandom);
         col_in   = 4'($urandom);
         cnt_end  = 1'($urandom);
         @(posedge clk); #1;
      end
      check("rst_key_code",    64'(key_code),    64'd0);
      check("rst_key_valid",   64'(key_valid),   64'd0);
      check("rst_key_down",    64'(key_down),    64'd0);
      check("rst_key_release", 64'(key_release), 64'd0);
      row_scan = ROW_IDLE; col_in = COL_IDLE; cnt_end = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Idle frames: no pulses
      none_frames(3);
      check("idle_key_down", 64'(key_down), 64'd0);

      // Press key 9 (row2, col1)
      key_frames(9, 3, 1'b0);
      expect_ev(1'b0, 4'h9);
      @(posedge clk); #1;
      check("press_key_down", 64'(key_down), 64'd1);
      check("press_key_code", 64'(key_code), 64'h9);

      // Another single key while held: no roll-over, no pulse
      key_frames(3, 2, 1'b0);
      check("hold_key_code", 64'(key_code), 64'h9);

      // Release bounce then real release
      none_frames(2);
      key_frames(9, 1, 1'b0);
      check("rel_bounce_down", 64'(key_down), 64'd1);
      none_frames(3);
      expect_ev(1'b1, 4'h9);
      @(posedge clk); #1;
      check("release_key_down", 64'(key_down), 64'd0);
      check("release_key_code", 64'(key_code), 64'h9);

      // Press bounce: 2 frames, 1 none, 3 frames
      key_frames(9, 2, 1'b0);
      none_frames(1);
      key_frames(9, 2, 1'b0);
      check("bounce_not_yet", 64'(key_down), 64'd0);
      key_frames(9, 1, 1'b0);
      expect_ev(1'b0, 4'h9);
      none_frames(3);
      expect_ev(1'b1, 4'h9);

      // Ghosting: two columns in row0, then hits in row0 and row2
      for (int i = 0; i < 4; i++) frame(16'hFFFC, 1'b0);
      for (int i = 0; i < 4; i++) frame(key_cols(1) & key_cols(10), 1'b0);
      check("ghost_key_down", 64'(key_down), 64'd0);

      // Mid-operation reset after 2 debounce frames, with discarded samples
      key_frames(6, 2, 1'b1);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      check("midrst_key_code", 64'(key_code), 64'd0);
      key_frames(6, 2, 1'b1);
      check("midrst_not_yet", 64'(key_down), 64'd0);
      key_frames(6, 1, 1'b1);
      expect_ev(1'b0, 4'h6);
      none_frames(3);
      expect_ev(1'b1, 4'h6);

      // Boundary key codes
      key_frames(0, 3, 1'b0);
      expect_ev(1'b0, 4'h0);
      none_frames(3);
      expect_ev(1'b1, 4'h0);
      key_frames(15, 3, 1'b1);
      expect_ev(1'b0, 4'hF);
      none_frames(3);
      expect_ev(1'b1, 4'hF);
      check("final_key_code", 64'(key_code), 64'hF);

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
